// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and stream framing constants for the boot loader
package loader_pkg;

  localparam logic [2:0] S_LEN_HI = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CHK    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    LEN_HI = S_LEN_HI,
    LEN_LO = S_LEN_LO,
    DATA   = S_DATA,
    CHK    = S_CHK,
    DONE   = S_DONE,
    ERROR  = S_ERROR
  } state_e;

endpackage

// File: rtl/word_packer.sv
// rtl/word_packer.sv - packs big-endian bytes into 32-bit words; word_valid pulses with the last byte
module word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (byte_valid) begin
      shift_d = {shift_q[15:0], byte_data};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  // The fourth byte completes the word combinationally so the top can register the write at this edge.
  assign word_valid = byte_valid && (cnt_q == 2'(WORD_BYTES - 1));
  assign word       = {shift_q, byte_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads a length-prefixed byte stream into instruction memory, then releases the pipeline
// Optional trailing checksum byte enabled by LOADER_CHECKSUM_EN.
module imem_boot_loader
  import loader_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              pipe_enable,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  localparam logic [16:0] MAX_N = 17'(MEM_WORDS);

  state_e            state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [15:0]       words_loaded_q, words_loaded_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              pipe_enable_q, pipe_enable_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              xfer;
  logic              pk_valid;
  logic [31:0]       pk_word;

`ifdef LOADER_CHECKSUM_EN
  localparam state_e FINISH_ST = CHK;
  logic [7:0] sum_q, sum_d;
`else
  localparam state_e FINISH_ST = DONE;
`endif

  assign in_ready = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                    (state_q == DATA)   || (state_q == CHK);
  assign xfer     = in_valid && in_ready;

  word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (xfer && (state_q == DATA)),
    .byte_data  (in_data),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    words_loaded_d = words_loaded_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d          = (xfer && (state_q != CHK)) ? sum_q + in_data : sum_q;
`endif
    case (state_q)
      LEN_HI: if (xfer) begin
        n_d     = {in_data, 8'h00};
        state_d = LEN_LO;
      end
      LEN_LO: if (xfer) begin
        n_d = {n_q[15:8], in_data};
        if (n_d == 16'd0)              state_d = FINISH_ST;
        else if ({1'b0, n_d} > MAX_N)  state_d = ERROR;
        else                           state_d = DATA;
      end
      DATA: if (pk_valid) begin
        mem_we_d       = 1'b1;
        mem_addr_d     = ADDR_W'({words_loaded_q, 2'b00});
        mem_wdata_d    = pk_word;
        words_loaded_d = words_loaded_q + 16'd1;
        if (words_loaded_d == n_q) state_d = FINISH_ST;
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: if (xfer) begin
        state_d = (in_data == sum_q) ? DONE : ERROR;
      end
`endif
      default: ;
    endcase
    // pipe_enable lags DONE by one cycle so the final write lands before the first fetch.
    done_d        = (state_d == DONE);
    error_d       = (state_d == ERROR);
    pipe_enable_d = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= LEN_HI;
      n_q            <= 16'd0;
      words_loaded_q <= 16'd0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= 32'd0;
      pipe_enable_q  <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q          <= 8'd0;
`endif
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      words_loaded_q <= words_loaded_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      pipe_enable_q  <= pipe_enable_d;
      done_q         <= done_d;
      error_q        <= error_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q          <= sum_d;
`endif
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign pipe_enable  = pipe_enable_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - randomized stream loads checked against a byte-history model of the loader
module tb_imem_boot_loader;

  localparam int MEM_WORDS = 256;
  localparam int ADDR_W    = 32;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CKS = 1'b1;
`else
  localparam bit CKS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_ready, mem_we, pipe_enable, done, error;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [15:0]       words_loaded;

  imem_boot_loader #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .pipe_enable(pipe_enable),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: everything follows from the list of bytes accepted since the last reset.
  logic [7:0]  got[$];
  int          n_words;
  bit          exp_ready, exp_we, exp_pipe, exp_done, exp_error, fresh;
  logic [31:0] exp_addr, exp_wdata;
  int          exp_wl;

  task automatic model_edge(input bit v, input logic [7:0] d, input bit rst);
    int k, dw;
    logic [7:0] s;
    exp_we = 1'b0;
    if (rst) begin
      got.delete();
      exp_ready = 1'b1; exp_pipe = 1'b0; exp_done = 1'b0; exp_error = 1'b0;
      exp_wl = 0; exp_addr = 0; exp_wdata = 0; fresh = 1'b1; n_words = 0;
      return;
    end
    exp_pipe = exp_done;
    if (!(v && exp_ready)) return;
    got.push_back(d);
    k = got.size();
    if (k == 2) begin
      n_words = {got[0], got[1]};
      if (n_words > MEM_WORDS) exp_error = 1'b1;
      else if (n_words == 0 && !CKS) exp_done = 1'b1;
    end else if (k > 2 && k <= 2 + 4 * n_words) begin
      dw = k - 2;
      if (dw % 4 == 0) begin
        exp_we    = 1'b1;
        exp_addr  = 4 * (dw / 4 - 1);
        exp_wdata = {got[k-4], got[k-3], got[k-2], got[k-1]};
        exp_wl    = dw / 4;
        fresh     = 1'b0;
        if (dw / 4 == n_words && !CKS) exp_done = 1'b1;
      end
    end else if (CKS && k == 3 + 4 * n_words) begin
      s = 8'd0;
      for (int i = 0; i < k - 1; i++) s = s + got[i];
      if (d == s) exp_done = 1'b1;
      else        exp_error = 1'b1;
    end
    exp_ready = !(exp_done || exp_error);
  endtask

  // Compare process plus write log for the literal checks.
  bit          chk_en = 1'b0;
  int          cyc = 0;
  int          last_we_cyc = 0;
  int          pipe_rise_cyc = 0;
  bit          pipe_prev = 1'b0;
  logic [31:0] log_a[$];
  logic [31:0] log_d[$];

  always @(negedge clk) begin
    if (chk_en) begin
      cyc++;
      chk("in_ready", in_ready, exp_ready);
      chk("mem_we", mem_we, exp_we);
      chk("pipe_enable", pipe_enable, exp_pipe);
      chk("done", done, exp_done);
      chk("error", error, exp_error);
      chk("words_loaded", words_loaded, exp_wl);
      if (exp_we || fresh) begin
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wdata", mem_wdata, exp_wdata);
      end
      if (mem_we) begin
        log_a.push_back(mem_addr);
        log_d.push_back(mem_wdata);
        last_we_cyc = cyc;
      end
      if (pipe_enable && !pipe_prev) pipe_rise_cyc = cyc;
      pipe_prev = pipe_enable;
    end
  end

  task automatic drive(input bit v, input logic [7:0] d, input bit rst);
    in_valid = v; in_data = d; reset = rst;
    @(posedge clk);
    model_edge(v, d, rst);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 8'h00, 1'b1);
    log_a.delete(); log_d.delete();
  endtask

  task automatic send(input logic [7:0] bytes[$]);
    foreach (bytes[i]) drive(1'b1, bytes[i], 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 1'b0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] s;
    int n, rst_at;
    bit v, cut;

    drive(1'b0, 8'h00, 1'b1);
    chk_en = 1'b1;
    do_reset();
    chk("reset_in_ready", in_ready, 1);
    chk("reset_pipe", pipe_enable, 0);

    // Two-word load from the reference stream.
    q = '{8'h00, 8'h02, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h08};
    if (CKS) q.push_back(8'h9B);
    send(q);
    idle(3);
    chk("t1_writes", log_a.size(), 2);
    chk("t1_addr0", log_a[0], 32'h0);
    chk("t1_data0", log_d[0], 32'h8C010004);
    chk("t1_addr1", log_a[1], 32'h4);
    chk("t1_data1", log_d[1], 32'h00000008);
    chk("t1_done", done, 1);
`ifndef LOADER_CHECKSUM_EN
    chk("t1_pipe_lag", pipe_rise_cyc - last_we_cyc, 1);
`endif

    // Oversized header.
    do_reset();
    send('{8'h01, 8'h01});
    idle(3);
    chk("t2_error", error, 1);
    chk("t2_writes", log_a.size(), 0);
    chk("t2_in_ready", in_ready, 0);
    chk("t2_pipe", pipe_enable, 0);

    // One word with valid toggling.
    do_reset();
    q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    if (CKS) q.push_back(8'h39);
    foreach (q[i]) begin
      drive(1'b1, q[i], 1'b0);
      drive(1'b0, 8'h5A, 1'b0);
    end
    idle(2);
    chk("t3_writes", log_a.size(), 1);
    chk("t3_data", log_d[0], 32'hDEADBEEF);
    chk("t3_wl", words_loaded, 1);

    // Reset in the middle of a three-word load, then a fresh one-word load.
    do_reset();
    send('{8'h00, 8'h03, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16});
    do_reset();
    chk("t4_wl", words_loaded, 0);
    chk("t4_addr", mem_addr, 0);
    chk("t4_pipe", pipe_enable, 0);
    q = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    if (CKS) q.push_back(8'h0F);
    send(q);
    idle(2);
    chk("t4_writes", log_a.size(), 1);
    chk("t4_addr0", log_a[0], 32'h0);
    chk("t4_data0", log_d[0], 32'hAABBCCDD);

    // Empty program.
    do_reset();
    q = '{8'h00, 8'h00};
    if (CKS) q.push_back(8'h00);
    send(q);
    idle(2);
    chk("t5_done", done, 1);
    chk("t5_writes", log_a.size(), 0);

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    send('{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02});
    idle(2);
    chk("t6_good_done", done, 1);
    do_reset();
    send('{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h03});
    idle(2);
    chk("t6_bad_error", error, 1);
    chk("t6_bad_pipe", pipe_enable, 0);
`endif

    // Randomized loads, including the full-depth boundary once.
    for (int it = 0; it < 40; it++) begin
      do_reset();
      if (it == 0)                       n = MEM_WORDS;
      else if ($urandom_range(0, 7) == 0) n = $urandom_range(MEM_WORDS + 1, MEM_WORDS + 40);
      else                               n = $urandom_range(0, 6);
      q.delete();
      q.push_back(8'(n >> 8));
      q.push_back(8'(n));
      if (n <= MEM_WORDS)
        for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
      if (CKS) begin
        s = 8'd0;
        foreach (q[i]) s = s + q[i];
        q.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : s);
      end
      cut    = ($urandom_range(0, 9) == 0);
      rst_at = $urandom_range(0, q.size() - 1);
      for (int idx = 0; idx < q.size(); ) begin
        if (cut && idx == rst_at) begin
          do_reset();
          break;
        end
        v = ($urandom_range(0, 9) < 7);
        drive(v, v ? q[idx] : 8'($urandom), 1'b0);
        if (v) idx++;
      end
      for (int i = 0; i < 4; i++) drive($urandom_range(0, 1) == 1, 8'($urandom), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
